// File: rtl/cacheline_adapter_pkg.sv
// Shared types for the cache-line to 4-beat burst adapter.
// Latency: none (types and constants only); backpressure: n/a.
package adapter_types;

  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side line port plus memory-side burst port, grouped as one bundle.
// slave = adapter view, master = view of whatever drives the cache/memory ends.
interface cacheline_adapter_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) ();

  logic                   read_i;
  logic                   write_i;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// Latency: 6 cycles per line minimum; memory stalls via resp_i, one line in flight.
module cacheline_adapter
  import adapter_types::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst,
  cacheline_adapter_if.slave bus
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] RD_BURST = ST_RD_BURST;
  localparam logic [1:0] WR_BURST = ST_WR_BURST;
  localparam logic [1:0] DONE     = ST_DONE;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  logic [1:0]            state_q, state_d;
  beat_idx_t             beat_q, beat_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          buf_d   = bus.line_i;
          addr_d  = bus.address_i & ALIGN_MASK;
          beat_d  = '0;
          state_d = WR_BURST;
        end else if (bus.read_i) begin
          addr_d  = bus.address_i & ALIGN_MASK;
          beat_d  = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (bus.resp_i) begin
          line_d[BURST_WIDTH*beat_q +: BURST_WIDTH] = bus.burst_i;
          beat_d = beat_q + beat_idx_t'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (bus.resp_i) begin
          beat_d = beat_q + beat_idx_t'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset mid-burst also discards any partially assembled line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.read_o    = (state_q == RD_BURST);
  assign bus.write_o   = (state_q == WR_BURST);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.burst_o   = (state_q == WR_BURST) ? buf_q[BURST_WIDTH*beat_q +: BURST_WIDTH]
                                               : '0;

endmodule
